// File: rtl/usb_multi_ep_protocol_ctrl.sv
// USB full-speed transaction-level protocol controller for NUM_EP endpoints.
// Sequences OUT and IN transactions between the RX/TX packet engines, the AHB
// side and the shared data buffer. It keeps one DATA0/DATA1 toggle per endpoint.
// Optional feature macro PROTO_HS_TIMEOUT_EN: when defined, the wait for the host
// handshake after IN data gives up after HS_TO_CYC cycles.
module usb_multi_ep_protocol_ctrl #(
  parameter int NUM_EP    = 2,
  parameter int OCC_W     = 7,
  parameter int HS_TO_CYC = 800,
  localparam int EP_W     = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [2:0]       rx_packet,
  input  logic [3:0]       rx_endpoint,
  input  logic             rx_data_toggle,
  input  logic             tx_done,
  input  logic             buffer_reserved,
  input  logic [EP_W-1:0]  tx_ep,
  input  logic [OCC_W-1:0] tx_packet_data_size,
  input  logic [OCC_W-1:0] buffer_occupancy,
  output logic             rx_data_ready,
  output logic             rx_transfer_active,
  output logic             rx_error,
  output logic             tx_transfer_active,
  output logic             tx_error,
  output logic             clear,
  output logic [1:0]       tx_packet,
  output logic             tx_data_toggle,
  output logic             d_mode,
  output logic [EP_W-1:0]  active_ep
);

  localparam logic [2:0] RX_IDLE = 3'd0;
  localparam logic [2:0] RX_DATA = 3'd1;
  localparam logic [2:0] RX_OUT  = 3'd2;
  localparam logic [2:0] RX_IN   = 3'd3;
  localparam logic [2:0] RX_ACK  = 3'd4;
  localparam logic [2:0] RX_NAK  = 3'd5;
  localparam logic [2:0] RX_BAD  = 3'd6;

  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_DATA = 2'd1;
  localparam logic [1:0] TX_ACK  = 2'd2;
  localparam logic [1:0] TX_NAK  = 2'd3;

  typedef enum logic [4:0] {
    S_IDLE, S_IGN_TOKEN, S_IGN_DATA, S_OUT_WAIT, S_OUT_DATA, S_BAD_WAIT,
    S_FLUSH, S_DUP_ACK, S_ACK_START, S_ACK_SEND, S_ACK_WAIT, S_DRAIN,
    S_HOLD_TOKEN, S_HOLD_DATA, S_AHB_FILL, S_TX_DATA, S_TX_STREAM, S_TX_WAIT,
    S_HS_WAIT, S_NAK_START, S_NAK_SEND, S_NAK_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [NUM_EP-1:0] toggle_q, toggle_d;
  logic [EP_W-1:0]   activeEp_q, activeEp_d;
  logic              rxToggle_q, rxToggle_d;
  logic              goodData_q, goodData_d;
  logic              nakOut_q, nakOut_d;
  logic              rxDataReady_q, rxDataReady_d;
  logic              rxError_q, rxError_d;
  logic              txError_q, txError_d;
  logic              clear_q, clear_d;
  logic              rxActive_q, rxActive_d;
  logic              txActive_q, txActive_d;
  logic [1:0]        txPacket_q, txPacket_d;
  logic              txDataToggle_q, txDataToggle_d;

  logic              takeToken, hsAck, hsFail;
  logic              tokenSeen, epValid, inReady;
  logic [EP_W-1:0]   tokenEp;
  logic [31:0]       tokenEpWide;

  assign tokenSeen   = (rx_packet == RX_OUT) || (rx_packet == RX_IN);
  assign tokenEpWide = 32'(rx_endpoint);
  assign epValid     = tokenEpWide < 32'(NUM_EP);
  assign tokenEp     = rx_endpoint[EP_W-1:0];
  // IN data is ready to go only when it belongs to the token's endpoint and the
  // AHB side has finished loading every byte it announced.
  assign inReady     = buffer_reserved && (tx_ep == tokenEp) &&
                       (buffer_occupancy == tx_packet_data_size);

`ifdef PROTO_HS_TIMEOUT_EN
  localparam int              CNT_W   = $clog2(HS_TO_CYC + 1);
  localparam logic [CNT_W-1:0] HS_LAST = CNT_W'(HS_TO_CYC);
  logic [CNT_W-1:0] hsCnt_q;

  // Handshake wait counter restarts from zero on every entry to HS_WAIT
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                  hsCnt_q <= '0;
    else if (state_q == S_HS_WAIT) hsCnt_q <= hsCnt_q + 1'b1;
    else                         hsCnt_q <= '0;
  end
`endif

  // Next-state logic plus the sticky status and toggle bookkeeping
  always_comb begin
    state_d       = state_q;
    toggle_d      = toggle_q;
    activeEp_d    = activeEp_q;
    rxToggle_d    = rxToggle_q;
    goodData_d    = goodData_q;
    nakOut_d      = nakOut_q;
    rxDataReady_d = rxDataReady_q;
    rxError_d     = rxError_q;
    txError_d     = txError_q;
    takeToken     = 1'b0;
    hsAck         = 1'b0;
    hsFail        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tokenSeen) begin
          if (!epValid) begin
            state_d = (rx_packet == RX_OUT) ? S_IGN_TOKEN : S_IGN_DATA;
          end else begin
            takeToken = 1'b1;
            if (rx_packet == RX_OUT) begin
              state_d = S_OUT_WAIT;
            end else if (inReady) begin
              state_d = S_TX_DATA;
            end else begin
              state_d  = S_NAK_START;
              nakOut_d = 1'b0;
            end
          end
        end else if (rx_packet == RX_BAD) begin
          state_d  = S_NAK_START;
          nakOut_d = 1'b1;
        end else if (buffer_reserved) begin
          state_d = S_AHB_FILL;
        end
      end
      S_IGN_TOKEN: if ((rx_packet == RX_DATA) || (rx_packet == RX_BAD)) state_d = S_IGN_DATA;
      S_IGN_DATA:  if (rx_packet == RX_IDLE) state_d = S_IDLE;
      S_OUT_WAIT: begin
        if (rx_packet == RX_DATA) begin
          state_d    = S_OUT_DATA;
          rxToggle_d = rx_data_toggle;
        end else if (rx_packet == RX_BAD) begin
          state_d = S_BAD_WAIT;
        end
      end
      S_OUT_DATA: begin
        if (rx_packet == RX_IDLE) begin
          goodData_d = (rxToggle_q == toggle_q[activeEp_q]);
          state_d    = (rxToggle_q == toggle_q[activeEp_q]) ? S_ACK_START : S_DUP_ACK;
        end else if (rx_packet == RX_BAD) begin
          state_d = S_BAD_WAIT;
        end
      end
      S_BAD_WAIT: if (rx_packet == RX_IDLE) state_d = S_FLUSH;
      S_FLUSH: begin
        state_d  = S_NAK_START;
        nakOut_d = 1'b1;
      end
      S_DUP_ACK: state_d = S_ACK_START;
      S_ACK_START: begin
        state_d = S_ACK_SEND;
        if (goodData_q) begin
          toggle_d[activeEp_q] = ~toggle_q[activeEp_q];
          rxDataReady_d        = 1'b1;
        end
      end
      S_ACK_SEND: state_d = S_ACK_WAIT;
      S_ACK_WAIT: if (tx_done) state_d = S_DRAIN;
      S_DRAIN: begin
        if (buffer_occupancy == '0) begin
          state_d = S_IDLE;
        end else if (tokenSeen && epValid) begin
          takeToken = 1'b1;
          nakOut_d  = (rx_packet == RX_OUT);
          state_d   = (rx_packet == RX_OUT) ? S_HOLD_TOKEN : S_NAK_START;
        end
      end
      S_HOLD_TOKEN: if ((rx_packet == RX_DATA) || (rx_packet == RX_BAD)) state_d = S_HOLD_DATA;
      S_HOLD_DATA:  if (rx_packet == RX_IDLE) state_d = S_NAK_START;
      S_AHB_FILL: begin
        if (tokenSeen && epValid) begin
          takeToken = 1'b1;
          if (rx_packet == RX_OUT) begin
            state_d  = S_HOLD_TOKEN;
            nakOut_d = 1'b1;
          end else if (inReady) begin
            state_d = S_TX_DATA;
          end else begin
            state_d  = S_NAK_START;
            nakOut_d = 1'b0;
          end
        end else if (!buffer_reserved) begin
          state_d = S_IDLE;
        end
      end
      S_TX_DATA:   state_d = S_TX_STREAM;
      S_TX_STREAM: if (buffer_occupancy == '0) state_d = S_TX_WAIT;
      S_TX_WAIT:   if (tx_done) state_d = S_HS_WAIT;
      S_HS_WAIT: begin
        if (rx_packet == RX_ACK) begin
          state_d = S_IDLE;
          hsAck   = 1'b1;
        end else if (rx_packet == RX_NAK) begin
          state_d = S_IDLE;
          hsFail  = 1'b1;
        end
`ifdef PROTO_HS_TIMEOUT_EN
        else if (hsCnt_q == HS_LAST) begin
          state_d = S_IDLE;
          hsFail  = 1'b1;
        end
`endif
      end
      S_NAK_START: begin
        state_d = S_NAK_SEND;
        if (nakOut_q) rxError_d = 1'b1;
      end
      S_NAK_SEND: state_d = S_NAK_WAIT;
      S_NAK_WAIT: if (tx_done) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (takeToken) begin
      activeEp_d    = tokenEp;
      rxDataReady_d = 1'b0;
      rxError_d     = 1'b0;
      txError_d     = 1'b0;
    end
    if (hsAck)  toggle_d[activeEp_q] = ~toggle_q[activeEp_q];
    if (hsFail) txError_d = 1'b1;
  end

  // Moore outputs decoded from the next state so they register alongside it
  always_comb begin
    rxActive_d     = (state_d == S_OUT_DATA);
    txActive_d     = 1'b0;
    txPacket_d     = TX_IDLE;
    txDataToggle_d = 1'b0;
    clear_d        = hsFail || (state_d == S_FLUSH) || (state_d == S_DUP_ACK);
    case (state_d)
      S_ACK_START, S_ACK_WAIT, S_NAK_START, S_NAK_WAIT, S_TX_STREAM, S_TX_WAIT:
        txActive_d = 1'b1;
      S_ACK_SEND: begin
        txActive_d = 1'b1;
        txPacket_d = TX_ACK;
      end
      S_NAK_SEND: begin
        txActive_d = 1'b1;
        txPacket_d = TX_NAK;
      end
      S_TX_DATA: begin
        txActive_d     = 1'b1;
        txPacket_d     = TX_DATA;
        txDataToggle_d = toggle_q[activeEp_d];
      end
      default: txActive_d = 1'b0;
    endcase
  end

  // State, toggles and registered outputs, all cleared by reset
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= S_IDLE;
      toggle_q       <= '0;
      activeEp_q     <= '0;
      rxToggle_q     <= 1'b0;
      goodData_q     <= 1'b0;
      nakOut_q       <= 1'b0;
      rxDataReady_q  <= 1'b0;
      rxError_q      <= 1'b0;
      txError_q      <= 1'b0;
      clear_q        <= 1'b0;
      rxActive_q     <= 1'b0;
      txActive_q     <= 1'b0;
      txPacket_q     <= TX_IDLE;
      txDataToggle_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      toggle_q       <= toggle_d;
      activeEp_q     <= activeEp_d;
      rxToggle_q     <= rxToggle_d;
      goodData_q     <= goodData_d;
      nakOut_q       <= nakOut_d;
      rxDataReady_q  <= rxDataReady_d;
      rxError_q      <= rxError_d;
      txError_q      <= txError_d;
      clear_q        <= clear_d;
      rxActive_q     <= rxActive_d;
      txActive_q     <= txActive_d;
      txPacket_q     <= txPacket_d;
      txDataToggle_q <= txDataToggle_d;
    end
  end

  assign rx_data_ready      = rxDataReady_q;
  assign rx_transfer_active = rxActive_q;
  assign rx_error           = rxError_q;
  assign tx_transfer_active = txActive_q;
  assign tx_error           = txError_q;
  assign clear              = clear_q;
  assign tx_packet          = txPacket_q;
  assign tx_data_toggle     = txDataToggle_q;
  assign d_mode             = txActive_q;
  assign active_ep          = activeEp_q;

endmodule
